// File: rtl/hpu_pkg.sv
// Shared definitions for the HPU result path: word width, beat-count helper,
// collector FIFO entry layout and serializer states.
package hpu_pkg;

    localparam int WORD_W  = 32;
    localparam int HPU_DIM = 1023;

    typedef struct packed {
        logic             tag;
        logic [HPU_DIM:0] vec;
    } col_entry_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_t;

    function automatic int beats(input int dim, input int word = WORD_W);
        return (dim + 1) / word;
    endfunction

endpackage

// File: rtl/vec_fifo.sv
// Vector FIFO with registered read data and a second write port that lands
// in the slot after the first one, used when two entries arrive together.
module vec_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push2,
    input  logic [WIDTH-1:0] push2_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             two_free
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("vec_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             wr1, wr2, rd;

    // The second entry is only written when both slots are free; occupancy
    // is judged before any same-cycle pop.
    always_comb begin
        full      = (count_q == DEPTH_C);
        empty     = (count_q == '0);
        two_free  = (count_q <= DEPTH_C - CNT_W'(2));
        wr1       = push & ~full;
        wr2       = push & push2 & two_free;
        rd        = pop & ~empty;
        rd_data_d = rd ? mem_q[rd_ptr_q] : rd_data_q;
        wr_ptr_d  = wr_ptr_q + PTR_W'(wr1) + PTR_W'(wr2);
        rd_ptr_d  = rd_ptr_q + PTR_W'(rd);
        count_d   = count_q + CNT_W'(wr1) + CNT_W'(wr2) - CNT_W'(rd);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr1) begin
            mem_q[wr_ptr_q] <= push_data;
        end
        if (wr2) begin
            mem_q[wr_ptr_q + PTR_W'(1)] <= push2_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/store_collector.sv
// Collects hypervectors from the non-stallable compute core and streams them
// to the host as WORD-bit words, LSW first, flagging the final word of a run.
module store_collector
    import hpu_pkg::*;
#(
    parameter int DIM   = 1023,
    parameter int WORD  = WORD_W,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            store,
    input  logic [DIM:0]    core_result,
    input  logic            last,
    output logic            out_valid,
    output logic [WORD-1:0] out_data,
    output logic            out_last,
    input  logic            out_ready,
    output logic            overflow,
    output logic            done
);

    localparam int BEATS   = beats(DIM, WORD);
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ENTRY_W = DIM + 2;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    if ((DIM + 1) % WORD != 0) begin : g_word_chk
        $error("store_collector: DIM+1 must be a multiple of WORD");
    end

    logic [DIM:0]         hold_q, hold_d;
    logic                 hold_valid_q, hold_valid_d;
    ser_state_t           state_q, state_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic                 overflow_q, overflow_d;
    logic                 done_q, done_d;

    logic                 push1, push2, pop;
    logic [ENTRY_W-1:0]   push1_data, push2_data;
    logic [ENTRY_W-1:0]   fifo_rd;
    logic                 fifo_full, fifo_empty, fifo_two_free;
    logic                 orphan_last, fire, last_beat, drop;

    vec_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (~run),
        .push       (push1),
        .push_data  (push1_data),
        .push2      (push2),
        .push2_data (push2_data),
        .pop        (pop),
        .rd_data    (fifo_rd),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .two_free   (fifo_two_free)
    );

    // The newest vector stays in hold until a later store or last tells us
    // whether it is the final vector of the run.
    always_comb begin
        push1        = 1'b0;
        push2        = 1'b0;
        push1_data   = {1'b0, hold_q};
        push2_data   = {1'b1, core_result};
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        orphan_last  = 1'b0;
        if (!run) begin
            hold_valid_d = 1'b0;
        end else if (store) begin
            if (hold_valid_q) begin
                push1 = 1'b1;
                push2 = last;
            end else if (last) begin
                push1      = 1'b1;
                push1_data = {1'b1, core_result};
            end
            hold_d       = core_result;
            hold_valid_d = ~last;
        end else if (last) begin
            push1        = hold_valid_q;
            push1_data   = {1'b1, hold_q};
            orphan_last  = ~hold_valid_q;
            hold_valid_d = 1'b0;
        end
        drop = (push1 & fifo_full) | (push2 & ~fifo_two_free);
    end

    // The FIFO read register doubles as the vector being serialized; a new
    // pop on the final beat keeps the stream bubble-free.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        pop       = 1'b0;
        out_valid = (state_q == S_SEND);
        fire      = out_valid & out_ready;
        last_beat = (beat_q == LAST_BEAT);
        out_data  = '0;
        out_last  = 1'b0;
        if (out_valid) begin
            out_data = fifo_rd[beat_q * WORD +: WORD];
            out_last = fifo_rd[ENTRY_W-1] & last_beat;
        end
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_SEND;
                    beat_d  = '0;
                end
            end
            S_SEND: begin
                if (fire) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        pop     = ~fifo_empty;
                        state_d = fifo_empty ? S_IDLE : S_SEND;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!run) begin
            state_d = S_IDLE;
            beat_d  = '0;
            pop     = 1'b0;
        end
    end

    always_comb begin
        overflow_d = run & (overflow_q | drop);
        done_d     = run & ((fire & last_beat & fifo_rd[ENTRY_W-1]) | orphan_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            state_q      <= S_IDLE;
            beat_q       <= '0;
            overflow_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            state_q      <= state_d;
            beat_q       <= beat_d;
            overflow_q   <= overflow_d;
            done_q       <= done_d;
        end
    end

    assign overflow = overflow_q;
    assign done     = done_q;

endmodule

// File: tb/tb_store_collector.sv
// Directed bench for store_collector: streaming order, out_last/done timing,
// stalls, overflow, run flush and asynchronous reset.
module tb_store_collector;

    localparam int DIM   = 1023;
    localparam int W     = 32;
    localparam int BEATS = (DIM + 1) / W;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           run = 1'b0;
    logic           store = 1'b0;
    logic           last = 1'b0;
    logic           out_ready = 1'b0;
    logic [DIM:0]   core_result = '0;
    logic           out_valid, out_last, overflow, done;
    logic [W-1:0]   out_data;

    int             tests_run = 0;
    int             tests_failed = 0;
    int             cyc = 0;
    logic [W-1:0]   word_q[$];
    bit             last_q[$];
    int             cyc_q[$];
    logic [W-1:0]   exp_w[$];
    bit             exp_l[$];
    int             done_cnt = 0;
    int             done_cyc = -1;
    int             last_drive_cyc = 0;
    bit             rand_ready = 1'b0;
    bit             chk_stall = 1'b0;
    bit             prev_stall = 1'b0;

    store_collector #(
        .DIM   (DIM),
        .WORD  (W),
        .DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .store       (store),
        .core_result (core_result),
        .last        (last),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .overflow    (overflow),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Mid-cycle monitor: records accepted words and done pulses, and during
    // the random-ready run checks that a stalled word is held and correct.
    always @(negedge clk) begin
        if (rst_n) begin
            if (chk_stall && prev_stall)
                checkOutput("stall_valid_held", 64'(out_valid), 64'd1);
            if (chk_stall && out_valid && !out_ready && word_q.size() < exp_w.size())
                checkOutput("stall_data", 64'(out_data), 64'(exp_w[word_q.size()]));
            prev_stall = chk_stall && out_valid && !out_ready;
            if (out_valid && out_ready) begin
                word_q.push_back(out_data);
                last_q.push_back(out_last);
                cyc_q.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic applyStimulus(input bit st, input bit la, input logic [DIM:0] v);
        @(posedge clk);
        #1;
        store = st;
        last = la;
        core_result = v;
        if (la) last_drive_cyc = cyc;
    endtask

    function automatic logic [DIM:0] mkVec(input int seed);
        logic [DIM:0] v;
        v = '0;
        for (int k = 0; k < BEATS; k++)
            v[k*W +: W] = {8'(seed), 8'(k), 16'(seed * 131 + k * 7)};
        return v;
    endfunction

    function automatic logic [DIM:0] patA();
        logic [DIM:0] v;
        for (int i = 0; i <= DIM; i++) v[i] = (i % 3 == 0);
        return v;
    endfunction

    task automatic addVec(input logic [DIM:0] v, input bit fin);
        for (int k = 0; k < BEATS; k++) begin
            exp_w.push_back(v[k*W +: W]);
            exp_l.push_back(fin && k == BEATS - 1);
        end
    endtask

    task automatic clearAll();
        word_q.delete();
        last_q.delete();
        cyc_q.delete();
        exp_w.delete();
        exp_l.delete();
    endtask

    task automatic checkStream(input string name);
        checkOutput({name, "_count"}, 64'(word_q.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < word_q.size(); i++) begin
            checkOutput($sformatf("%s_w%0d", name, i), 64'(word_q[i]), 64'(exp_w[i]));
            checkOutput($sformatf("%s_l%0d", name, i), 64'(last_q[i]), 64'(exp_l[i]));
        end
    endtask

    task automatic waitDone(input string name, input int budget);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == start) checkOutput({name, "_done_timeout"}, 64'd0, 64'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DIM:0] va, vb, vc;
        logic [DIM:0] v [1:7];
        int start_done;
        int n;

        va = patA();
        vb = mkVec(2);
        vc = mkVec(3);
        for (int i = 1; i <= 7; i++) v[i] = mkVec(10 + i);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data", 64'(out_data), 64'd0);
        checkOutput("rst_out_last", 64'(out_last), 64'd0);
        checkOutput("rst_overflow", 64'(overflow), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run = 1'b1;
        out_ready = 1'b1;

        // Single vector then last
        clearAll();
        addVec(va, 1'b1);
        start_done = done_cnt;
        applyStimulus(1'b1, 1'b0, va);
        applyStimulus(1'b0, 1'b1, '0);
        applyStimulus(1'b0, 1'b0, '0);
        waitDone("t1", 200);
        checkStream("t1");
        if (word_q.size() > 1) begin
            checkOutput("t1_word0_hand", 64'(word_q[0]), 64'h49249249);
            checkOutput("t1_word1_hand", 64'(word_q[1]), 64'h92492492);
            checkOutput("t1_latency", 64'(cyc_q[0]), 64'(last_drive_cyc + 2));
            checkOutput("t1_done_cyc", 64'(done_cyc), 64'(cyc_q[word_q.size() - 1] + 1));
        end
        checkOutput("t1_done_cnt", 64'(done_cnt - start_done), 64'd1);

        // Three back-to-back vectors
        clearAll();
        addVec(va, 1'b0);
        addVec(vb, 1'b0);
        addVec(vc, 1'b1);
        applyStimulus(1'b1, 1'b0, va);
        applyStimulus(1'b1, 1'b0, vb);
        applyStimulus(1'b1, 1'b0, vc);
        applyStimulus(1'b0, 1'b1, '0);
        applyStimulus(1'b0, 1'b0, '0);
        waitDone("t2", 400);
        checkStream("t2");
        if (word_q.size() > 1)
            checkOutput("t2_no_bubble", 64'(cyc_q[word_q.size() - 1] - cyc_q[0]), 64'(3 * BEATS - 1));

        // Same with random back-pressure
        clearAll();
        addVec(va, 1'b0);
        addVec(vb, 1'b0);
        addVec(vc, 1'b1);
        rand_ready = 1'b1;
        chk_stall = 1'b1;
        applyStimulus(1'b1, 1'b0, va);
        applyStimulus(1'b1, 1'b0, vb);
        applyStimulus(1'b1, 1'b0, vc);
        applyStimulus(1'b0, 1'b1, '0);
        applyStimulus(1'b0, 1'b0, '0);
        waitDone("t3", 2000);
        rand_ready = 1'b0;
        chk_stall = 1'b0;
        out_ready = 1'b1;
        checkStream("t3");

        // Overflow: capacity is DEPTH+2 vectors with the output stalled
        clearAll();
        for (int i = 1; i <= 5; i++) addVec(v[i], 1'b0);
        addVec(v[7], 1'b1);
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) applyStimulus(1'b1, 1'b0, v[i]);
        applyStimulus(1'b0, 1'b0, '0);
        @(negedge clk);
        checkOutput("t4_overflow_after6", 64'(overflow), 64'd0);
        applyStimulus(1'b1, 1'b0, v[7]);
        applyStimulus(1'b0, 1'b0, '0);
        @(negedge clk);
        checkOutput("t4_overflow_after7", 64'(overflow), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        applyStimulus(1'b0, 1'b1, '0);
        applyStimulus(1'b0, 1'b0, '0);
        waitDone("t4", 600);
        checkStream("t4");
        checkOutput("t4_overflow_sticky", 64'(overflow), 64'd1);

        // run dropped mid-packet
        clearAll();
        for (int k = 0; k <= 10; k++) begin
            exp_w.push_back(v[1][k*W +: W]);
            exp_l.push_back(1'b0);
        end
        applyStimulus(1'b1, 1'b0, v[1]);
        applyStimulus(1'b1, 1'b0, v[2]);
        applyStimulus(1'b0, 1'b0, '0);
        n = 0;
        while (word_q.size() < 10 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("t5_reach_word10", 64'(word_q.size()), 64'd10);
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t5_valid_after_flush", 64'(out_valid), 64'd0);
        checkOutput("t5_overflow_after_flush", 64'(overflow), 64'd0);
        checkOutput("t5_last_after_flush", 64'(out_last), 64'd0);
        applyStimulus(1'b1, 1'b0, v[3]);
        applyStimulus(1'b0, 1'b0, '0);
        run = 1'b1;
        start_done = done_cnt;
        applyStimulus(1'b0, 1'b1, '0);
        applyStimulus(1'b0, 1'b0, '0);
        waitDone("t5", 20);
        checkOutput("t5_orphan_done_cyc", 64'(done_cyc), 64'(last_drive_cyc + 1));
        checkOutput("t5_done_cnt", 64'(done_cnt - start_done), 64'd1);
        repeat (40) @(posedge clk);
        checkStream("t5");

        // Asynchronous reset mid-packet
        clearAll();
        applyStimulus(1'b1, 1'b0, va);
        applyStimulus(1'b0, 1'b1, '0);
        applyStimulus(1'b0, 1'b0, '0);
        n = 0;
        while (word_q.size() < 5 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("t6_reach_word5", 64'(word_q.size()), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("t6_rst_data", 64'(out_data), 64'd0);
        checkOutput("t6_rst_last", 64'(out_last), 64'd0);
        checkOutput("t6_rst_overflow", 64'(overflow), 64'd0);
        checkOutput("t6_rst_done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clearAll();
        addVec(vb, 1'b1);
        start_done = done_cnt;
        applyStimulus(1'b1, 1'b1, vb);
        applyStimulus(1'b0, 1'b0, '0);
        waitDone("t6", 200);
        checkStream("t6");
        if (word_q.size() > 0)
            checkOutput("t6_latency", 64'(cyc_q[0]), 64'(last_drive_cyc + 2));
        checkOutput("t6_done_cnt", 64'(done_cnt - start_done), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/store_collector.md
# store_collector

Result-side partner of the HPU compute core. It consumes the core's `store`/`core_result`/`last` outputs, buffers whole hypervectors, and serializes them into 32-bit words on a valid/ready stream toward the host DMA. The core cannot be stalled, so the collector absorbs bursts in a vector FIFO and flags overflow rather than back-pressuring. It also marks the final word of a run with `out_last`.

## Interface
- `DIM`, 1023, MSB index of a hypervector (vector width DIM+1).
- `WORD`, 32, output word width; (DIM+1) % WORD == 0 is required, checked at elaboration.
- `DEPTH`, 4, vector FIFO entries; must be a power of 2, ≥2.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `run` in 1: accelerator active; low = synchronous flush.
- `store` in 1: core_result valid this cycle.
- `core_result` in DIM+1: vector from core.
- `last` in 1: one-cycle end-of-run pulse from core.
- `out_valid` out 1: output word valid.
- `out_data` out WORD: output word.
- `out_last` out 1: final word of the run.
- `out_ready` in 1: downstream accepts.
- `overflow` out 1: sticky, a vector was dropped.
- `done` out 1: one-cycle pulse when the run is fully drained.

## Operation
- **Hold register (1 entry, with tag bit):**
  - The newest stored vector waits in the hold register until the next `store` or `last`, so the collector knows whether it is final.
  - On `store` with hold occupied: push hold to the FIFO with tag=0, then load `core_result` into hold.
  - On `last` with hold occupied: push hold with tag=1 and empty the hold register.
  - If `store` and `last` occur in the same cycle: push the old hold (tag=0), then push `core_result` with tag=1. This needs 2 FIFO slots; each slot is checked independently.
  - Orphan `last` (hold empty, no `store`): nothing is pushed; `done` pulses the next cycle.
- **FIFO (DEPTH × (DIM+2) bits):**
  - A push into a full FIFO drops that vector and sets `overflow`.
  - `overflow` clears only on reset or `run` low.
- **Serializer:**
  - State machine: IDLE → SEND.
  - IDLE: if the FIFO is non-empty, pop into the shift register, set beat=0, go to SEND.
  - SEND: `out_data` = vector[WORD*beat +: WORD], so the LSW goes first.
  - beat advances on `out_valid & out_ready`.
  - After beat BEATS−1 (BEATS=(DIM+1)/WORD) is accepted, return to IDLE.
  - `out_last` = tag & (beat==BEATS−1).
  - `done` pulses the cycle after the tagged final beat is accepted.
- **`run` low:**
  - Clears hold, FIFO pointers, serializer (→IDLE), `overflow`.
  - A packet in progress is abandoned without `out_last`.
  - `store`/`last` are ignored while `run` is low.
- **Reset values:** `out_valid`=0, `out_data`=0, `out_last`=0, `overflow`=0, `done`=0; hold and FIFO empty; serializer IDLE.

## Timing
- `store` sampled in cycle t → hold loaded at end of t.
- Release by next `store`/`last` in cycle t2 → FIFO push at end of t2.
- Serializer pops at end of t2+1; first `out_valid` in t2+2.
- Minimum store-to-first-word latency is therefore 2 cycles after the releasing event.
- With `out_ready` held high: one word per cycle, no bubble between consecutive vectors. The pop happens in the same cycle the last beat is accepted when the FIFO is non-empty.
- `out_data`/`out_last` hold stable while `out_valid & ~out_ready`.
- `out_valid` never deasserts without a handshake, except on `run` low or reset.
- Storage capacity before overflow (out_ready=0): DEPTH+2 vectors (serializer + FIFO + hold).

## Structure
- Shared package `hpu_pkg`:
  - `WORD_W`=32
  - function `beats(dim)` = (dim+1)/WORD_W
  - typedef `col_entry_t` {tag, vec}
  - serializer state enum {S_IDLE, S_SEND}
- Sub-module `vec_fifo`:
  - parameterized width/depth
  - push/pop/full/empty
  - registered read data
  - 2-push variant via a second write port: `push2`, which requires 2 free slots; otherwise only the first entry is written and the other is dropped.
- Top module holds the hold register, serializer, flags.

## Test plan
- 1 store (vec bit i = i%3==0) then `last`, out_ready=1 → 32 words, word k = vec[32k+31:32k]; `out_last` only on word 31; `done` 1 cycle after.
- 3 back-to-back stores A,B,C then `last` → 96 contiguous words A,B,C; `out_last` only on word 95.
- Same as previous with out_ready random 50% → identical word sequence; data stable during stalls; no dropped or duplicated word.
- DEPTH=4, out_ready=0, 6 stores → `overflow`=0; 7th store → `overflow`=1. Then `last` and out_ready=1: 6 vectors out (stores 1–5 plus store 7); store 6 is missing.
- Stores active, `run` dropped at word 10 of vector 1 → next cycle `out_valid`=0, `overflow`=0. After `run` rises, `last` alone → `done` pulse, no output.
- `rst_n` asserted mid-packet asynchronously → all outputs 0 immediately; after release, a new store+`last` streams correctly.
